// File: rtl/alarm_comp_multi.sv
// -----------------------------------------------------------------------------
// alarm_comp_multi
//
// Multi-channel alarm comparator. Each channel compares the running timer word
// against its own alarm word. A new match on an enabled channel starts (or
// restarts) one shared ring period of RING_SECONDS seconds. Ringing can be
// stopped, and with the snooze option it can be postponed by SNOOZE_SECONDS.
// All outputs are registered.
//
// Build option:
//   ALARM_SNOOZE_EN  - when defined, alarm_snooze moves RING to SNOOZE. When
//                      undefined, there is no SNOOZE state, alarm_snooze is
//                      ignored and snoozing is constant 0.
//
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   asynchronous active-high reset
//   timer_data    in   current time (BCD hh:mm:ss)
//   alarm_data    in   channel i alarm at [i*DATA_WIDTH +: DATA_WIDTH]
//   alarm_enable  in   per-channel enable
//   alarm_stop    in   single-cycle stop request
//   alarm_snooze  in   single-cycle snooze request
//   alarm_output  out  high while ringing
//   alarm_source  out  mask of channels behind the current ring/snooze
//   snoozing      out  high while in SNOOZE
// -----------------------------------------------------------------------------
module alarm_comp_multi #(
  parameter int CHANNELS       = 4,
  parameter int DATA_WIDTH     = 24,
  parameter int SECOND_CNT     = 50000000,
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [DATA_WIDTH-1:0]          timer_data,
  input  logic [CHANNELS*DATA_WIDTH-1:0] alarm_data,
  input  logic [CHANNELS-1:0]            alarm_enable,
  input  logic                           alarm_stop,
  input  logic                           alarm_snooze,
  output logic                           alarm_output,
  output logic [CHANNELS-1:0]            alarm_source,
  output logic                           snoozing
);

  localparam int PRESC_W = (SECOND_CNT > 2) ? $clog2(SECOND_CNT) : 1;
  localparam int RING_W  = (RING_SECONDS > 1) ? $clog2(RING_SECONDS + 1) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SECOND_CNT - 1);
  localparam logic [RING_W-1:0]  RING_LOAD  = RING_W'(RING_SECONDS);
  localparam logic [RING_W-1:0]  RING_ONE   = RING_W'(1);

  if (CHANNELS < 1 || CHANNELS > 8 || DATA_WIDTH < 1 || SECOND_CNT < 2 ||
      RING_SECONDS < 1 || SNOOZE_SECONDS < 1) begin : g_param_check
    $error("alarm_comp_multi: parameter out of range");
  end

`ifdef ALARM_SNOOZE_EN
  localparam int SNZ_W = (SNOOZE_SECONDS > 1) ? $clog2(SNOOZE_SECONDS + 1) : 1;
  localparam logic [SNZ_W-1:0] SNZ_LOAD = SNZ_W'(SNOOZE_SECONDS);
  localparam logic [SNZ_W-1:0] SNZ_ONE  = SNZ_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RING = 2'd1
  } state_t;

  // Snooze request has no function in this build.
  logic unused_snooze;
  assign unused_snooze = alarm_snooze;
`endif

  state_t                state_reg, state_next;
  logic [CHANNELS-1:0]   eq, eq_q_reg, trig, kept;
  logic [CHANNELS-1:0]   source_reg, source_next;
  logic [PRESC_W-1:0]    presc_reg, presc_next;
  logic [RING_W-1:0]     ring_reg, ring_next;
  logic                  tick;
  logic                  go_idle;
  logic                  alarm_output_reg;
  logic                  snoozing_reg;
`ifdef ALARM_SNOOZE_EN
  logic [SNZ_W-1:0]      snz_reg, snz_next;
`endif

  // Per-channel equality against the timer.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    assign eq[gi] = (timer_data == alarm_data[gi*DATA_WIDTH +: DATA_WIDTH]);
  end

  // Only a fresh equality on an enabled channel fires; a sustained match or
  // enabling a channel that is already equal does not.
  assign trig = eq & ~eq_q_reg & alarm_enable;

  // A source bit whose channel is disabled is dropped. A source bit can only
  // have been set while its enable was high, so a low enable here means it fell.
  assign kept = source_reg & alarm_enable;

  assign tick = (presc_reg == PRESC_LAST);

  always_comb begin
    state_next  = state_reg;
    source_next = source_reg;
    presc_next  = presc_reg;
    ring_next   = ring_reg;
`ifdef ALARM_SNOOZE_EN
    snz_next    = snz_reg;
`endif
    go_idle     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (|trig) begin
          state_next  = ST_RING;
          source_next = trig;
          ring_next   = RING_LOAD;
          presc_next  = '0;
        end
      end

      ST_RING: begin
        presc_next = tick ? '0 : presc_reg + 1'b1;
        if (alarm_stop || (kept == '0)) begin
          go_idle = 1'b1;
        end else if (|trig) begin
          // Restart the full ring period and add the new channels.
          source_next = kept | trig;
          ring_next   = RING_LOAD;
          presc_next  = '0;
`ifdef ALARM_SNOOZE_EN
        end else if (alarm_snooze) begin
          state_next  = ST_SNOOZE;
          source_next = kept;
          snz_next    = SNZ_LOAD;
          presc_next  = '0;
`endif
        end else begin
          source_next = kept;
          if (tick) begin
            if (ring_reg == RING_ONE) begin
              go_idle = 1'b1;
            end else begin
              ring_next = ring_reg - 1'b1;
            end
          end
        end
      end

`ifdef ALARM_SNOOZE_EN
      ST_SNOOZE: begin
        presc_next = tick ? '0 : presc_reg + 1'b1;
        if (alarm_stop || (kept == '0)) begin
          go_idle = 1'b1;
        end else if (|trig) begin
          state_next  = ST_RING;
          source_next = kept | trig;
          ring_next   = RING_LOAD;
          presc_next  = '0;
        end else begin
          source_next = kept;
          if (tick) begin
            if (snz_reg == SNZ_ONE) begin
              // Snooze over: ring again for a full period. The prescaler
              // already wraps to 0 on this tick.
              state_next = ST_RING;
              ring_next  = RING_LOAD;
              snz_next   = '0;
            end else begin
              snz_next = snz_reg - 1'b1;
            end
          end
        end
      end
`endif

      default: begin
        go_idle = 1'b1;
      end
    endcase

    if (go_idle) begin
      state_next  = ST_IDLE;
      source_next = '0;
      presc_next  = '0;
      ring_next   = '0;
`ifdef ALARM_SNOOZE_EN
      snz_next    = '0;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      eq_q_reg         <= '0;
      source_reg       <= '0;
      presc_reg        <= '0;
      ring_reg         <= '0;
      alarm_output_reg <= 1'b0;
      snoozing_reg     <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_reg          <= '0;
`endif
    end else begin
      state_reg        <= state_next;
      eq_q_reg         <= eq;
      source_reg       <= source_next;
      presc_reg        <= presc_next;
      ring_reg         <= ring_next;
      alarm_output_reg <= (state_next == ST_RING);
`ifdef ALARM_SNOOZE_EN
      snoozing_reg     <= (state_next == ST_SNOOZE);
      snz_reg          <= snz_next;
`else
      snoozing_reg     <= 1'b0;
`endif
    end
  end

  assign alarm_output = alarm_output_reg;
  assign alarm_source = source_reg;
  assign snoozing     = snoozing_reg;

endmodule

// File: tb/tb_alarm_comp_multi.sv
// -----------------------------------------------------------------------------
// tb_alarm_comp_multi
//
// Directed scenarios followed by a randomized phase. A reference model tracks
// the alarm in terms of clocks remaining in the current ring/snooze period.
// -----------------------------------------------------------------------------
module tb_alarm_comp_multi;

  localparam int CH       = 2;
  localparam int DW       = 24;
  localparam int SC       = 4;
  localparam int RS       = 60;
  localparam int SS       = 5;
  localparam int RING_CLK = RS * SC;
  localparam int SNZ_CLK  = SS * SC;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ_EN = 1'b1;
`else
  localparam bit SNZ_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] timer_data = '0;
  logic [DW-1:0] a0 = 24'd1;
  logic [DW-1:0] a1 = 24'd2;
  logic [CH-1:0] alarm_enable = '0;
  logic          alarm_stop = 1'b0;
  logic          alarm_snooze = 1'b0;
  logic          alarm_output;
  logic [CH-1:0] alarm_source;
  logic          snoozing;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: mode 0 idle, 1 ring, 2 snooze; m_left = clocks remaining.
  int          m_mode = 0;
  int          m_left = 0;
  logic [CH-1:0] m_src = '0;
  logic [CH-1:0] m_prev_eq = '0;

  alarm_comp_multi #(
    .CHANNELS      (CH),
    .DATA_WIDTH    (DW),
    .SECOND_CNT    (SC),
    .RING_SECONDS  (RS),
    .SNOOZE_SECONDS(SS)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .timer_data  (timer_data),
    .alarm_data  ({a1, a0}),
    .alarm_enable(alarm_enable),
    .alarm_stop  (alarm_stop),
    .alarm_snooze(alarm_snooze),
    .alarm_output(alarm_output),
    .alarm_source(alarm_source),
    .snoozing    (snoozing)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_out"}, 32'(alarm_output), 32'(m_mode == 1));
    check({tag, "_src"}, 32'(alarm_source), 32'(m_src));
    check({tag, "_snz"}, 32'(snoozing),     32'(m_mode == 2));
  endtask

  task automatic model_reset();
    m_mode    = 0;
    m_left    = 0;
    m_src     = '0;
    m_prev_eq = '0;
  endtask

  // One rising edge of behaviour, using the inputs as they are at that edge.
  task automatic model_edge();
    logic [CH-1:0] eqv, trg, kept;
    eqv       = {timer_data == a1, timer_data == a0};
    trg       = eqv & ~m_prev_eq & alarm_enable;
    m_prev_eq = eqv;
    kept      = m_src & alarm_enable;
    if (m_mode == 0) begin
      if (trg != '0) begin
        m_mode = 1; m_left = RING_CLK; m_src = trg;
      end
    end else if (alarm_stop || kept == '0) begin
      m_mode = 0; m_left = 0; m_src = '0;
    end else if (trg != '0) begin
      m_mode = 1; m_left = RING_CLK; m_src = kept | trg;
    end else if (SNZ_EN && m_mode == 1 && alarm_snooze) begin
      m_mode = 2; m_left = SNZ_CLK; m_src = kept;
    end else begin
      m_src  = kept;
      m_left = m_left - 1;
      if (m_left == 0) begin
        if (m_mode == 1) begin
          m_mode = 0; m_src = '0;
        end else begin
          m_mode = 1; m_left = RING_CLK;
        end
      end
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    int cnt_out;
    int cnt_snz;

    // Reset state
    model_reset();
    #2;
    check_all("reset");
    @(posedge clock);
    #1;
    reset = 1'b0;

    // 1: single channel ring, exact length, no retrigger while held equal
    alarm_enable = 2'b01;
    timer_data   = 24'd0;
    repeat (3) cycle("t1_pre");
    timer_data = 24'd1;
    cycle("t1_trig");
    check("t1_out_now", 32'(alarm_output), 32'd1);
    check("t1_src_now", 32'(alarm_source), 32'h1);
    cnt_out = 1;
    for (int i = 0; i < 299; i++) begin
      if (i == 260) timer_data = 24'd0;
      cycle("t1_hold");
      if (alarm_output === 1'b1) cnt_out++;
    end
    check("t1_len", 32'(cnt_out), 32'(RING_CLK));

    // 2: enabling while already equal must not ring; a fresh match must
    alarm_enable = 2'b00;
    timer_data   = 24'd0;
    cycle("t2_a");
    timer_data = 24'd1;
    cycle("t2_b");
    alarm_enable = 2'b01;
    repeat (5) cycle("t2_en_eq");
    check("t2_no_ring", 32'(alarm_output), 32'd0);
    timer_data = 24'd0;
    cycle("t2_c");
    timer_data = 24'd1;
    cycle("t2_ring");
    check("t2_ring_on", 32'(alarm_output), 32'd1);
    repeat (10) cycle("t2_mid");
    alarm_stop = 1'b1;
    cycle("t2_stop");
    alarm_stop = 1'b0;
    check("t2_stopped", 32'(alarm_output), 32'd0);
    timer_data = 24'd0;
    repeat (3) cycle("t2_idle");

    // 3: second channel extends the ring
    alarm_enable = 2'b11;
    timer_data   = 24'd1;
    cycle("t3_ch0");
    repeat (99) cycle("t3_wait");
    timer_data = 24'd2;
    cycle("t3_ch1");
    check("t3_src11", 32'(alarm_source), 32'h3);
    cnt_out = 1;
    for (int i = 0; i < 299; i++) begin
      cycle("t3_run");
      if (alarm_output === 1'b1) cnt_out++;
    end
    check("t3_len", 32'(cnt_out), 32'(RING_CLK));
    timer_data = 24'd0;
    cycle("t3_end");

    // 4: disabling the only source channel ends the ring
    alarm_enable = 2'b01;
    timer_data   = 24'd1;
    cycle("t4_trig");
    repeat (10) cycle("t4_mid");
    alarm_enable = 2'b00;
    cycle("t4_dis");
    check("t4_idle", 32'(alarm_output), 32'd0);
    timer_data = 24'd0;
    cycle("t4_end");

    // 5: snooze at clock 20 of the ring
    alarm_enable = 2'b01;
    timer_data   = 24'd1;
    cycle("t5_trig");
    cnt_out = 1;
    cnt_snz = 0;
    repeat (19) begin
      cycle("t5_ring");
      if (alarm_output === 1'b1) cnt_out++;
    end
    alarm_snooze = 1'b1;
    cycle("t5_snz");
    alarm_snooze = 1'b0;
    if (alarm_output === 1'b1) cnt_out++;
    if (snoozing === 1'b1) cnt_snz++;
    for (int i = 0; i < 399; i++) begin
      cycle("t5_run");
      if (alarm_output === 1'b1) cnt_out++;
      if (snoozing === 1'b1) cnt_snz++;
    end
    check("t5_out_len", 32'(cnt_out), SNZ_EN ? 32'(RING_CLK + 20) : 32'(RING_CLK));
    check("t5_snz_len", 32'(cnt_snz), SNZ_EN ? 32'(SNZ_CLK) : 32'd0);
    timer_data = 24'd0;
    cycle("t5_end");

    // 6: asynchronous reset mid-ring, retrigger after release
    timer_data = 24'd1;
    cycle("t6_trig");
    repeat (10) cycle("t6_mid");
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("t6_rst");
    @(posedge clock);
    #1;
    check_all("t6_rst_hold");
    reset = 1'b0;
    cycle("t6_retrig");
    check("t6_ring_again", 32'(alarm_output), 32'd1);
    alarm_stop = 1'b1;
    cycle("t6_stop");
    alarm_stop = 1'b0;

    // 7: randomized traffic
    for (int i = 0; i < 3000; i++) begin
      timer_data   = 24'($urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0) a0 = 24'($urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0) a1 = 24'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) alarm_enable[0] = ~alarm_enable[0];
      if ($urandom_range(0, 31) == 0) alarm_enable[1] = ~alarm_enable[1];
      alarm_stop   = ($urandom_range(0, 99) == 0);
      alarm_snooze = ($urandom_range(0, 15) == 0);
      cycle("rand");
    end
    alarm_stop   = 1'b0;
    alarm_snooze = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
